conv_frame_ctrl: RTL and testbench
==================================

Name: conv_frame_ctrl

Overview:
- Frame-level sequencer for the Bayer→grey→3×3 Sobel edge datapath.
- Synchronises and debounces the raw filter-direction switch, and applies direction changes only at start-of-frame (SOF).
- Masks output while the line buffers hold stale data (first frame after reset, after a stream timeout, and optionally the frame after a direction change).
- Generates the registered border-valid enable, a frame counter and debug state for the downstream pixel stream.

Parameters:
X_LO, 10, first X_Cont (inclusive) where the edge result is valid
X_HI, 1269, last X_Cont (inclusive) where the edge result is valid
Y_LO, 10, first Y_Cont (inclusive) where the edge result is valid
Y_HI, 939, last Y_Cont (inclusive) where the edge result is valid
DEB_CYCLES, 50000, clock cycles the synchronised switch must be stable before it is accepted (≥2)
TIMEOUT_CYC, 4000000, consecutive cycles with iDVAL low that declare the stream lost (≥2)
MASK_ON_SWITCH, 1, 1 = mask the whole frame following a direction change; 0 = no mask on change

Ports:
iCLK  in  1  pixel clock; all logic on its rising edge
iRST  in  1  reset; asynchronous, active-low
iSW  in  1  raw filter-direction switch; asynchronous to iCLK
iDVAL  in  1  pixel-stream data valid
iX_Cont  in  11  pixel column counter
iY_Cont  in  11  pixel row counter
oIsHorz  out  1  applied filter direction (1 = horizontal kernel)
oEdgeEn  out  1  1 = pass the edge result; 0 = force output to zero
oModePend  out  1  debounced switch differs from oIsHorz
oFrameCnt  out  16  number of SOF events since reset; wraps at 65535→0
oState  out  2  FSM state: 00 WAIT_SOF, 01 WARM, 10 RUN

Behaviour:
- Reset: iRST low asynchronously clears everything. oIsHorz=0, oEdgeEn=0, oModePend=0, oFrameCnt=0, oState=WAIT_SOF. Synchroniser flops, debounced value and sof_armed (SOF re-arm flag) reset to 0. The debounce counter resets to 0; the timeout counter resets to 0. Reset applies identically at any point mid-frame.
- Synchroniser: iSW passes through 2 flops to give sw_s.
- Debounce:
  - Counter clears whenever sw_s equals the debounced value.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, the debounced value takes sw_s and the counter clears.
  - Total latency from iSW edge to debounced change is DEB_CYCLES+2 cycles.
  - Glitches shorter than DEB_CYCLES are ignored.
- oModePend is registered and equals (debounced != oIsHorz).
- SOF:
  - SOF = iDVAL & (iX_Cont==0) & (iY_Cont==0) & sof_armed.
  - sof_armed clears on SOF and sets on any cycle with iY_Cont != 0.
  - So a held (0,0) coordinate yields exactly one SOF.
- Frame counter: oFrameCnt increments by 1 on every SOF, in every state.
- Timeout counter:
  - Clears on any cycle with iDVAL=1; otherwise increments, saturating at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC while in WARM or RUN forces WAIT_SOF on the next edge.
  - Timeout takes priority over an SOF in the same cycle.
- FSM:
  - WAIT_SOF → WARM on SOF. oIsHorz loads the debounced value.
  - WARM → RUN on the next SOF. oIsHorz loads the debounced value.
  - RUN → on SOF with debounced != oIsHorz: oIsHorz loads the debounced value; if MASK_ON_SWITCH=1 go to WARM, otherwise stay in RUN.
  - RUN → on SOF with no change: stay in RUN.
  - oIsHorz changes only on these SOF-qualified transitions, never mid-frame.
- Simultaneous debounce update and SOF: the SOF uses the pre-update debounced value; the new direction waits for the following SOF.
- oEdgeEn:
  - Registered, 1-cycle latency: value at cycle n+1 = (state==RUN at cycle n) & X_LO≤iX_Cont≤X_HI & Y_LO≤iY_Cont≤Y_HI. Comparisons are unsigned 11-bit.
  - It is 0 in WAIT_SOF and WARM.
  - In the cycle after a transition into RUN, oEdgeEn evaluates using the old state, so it is 0.
- oState: registered encoding of the current FSM state.

Test Plan:
- Reset/first frames (params X_LO=2, X_HI=5, Y_LO=1, Y_HI=2, 8×4 frames, DEB_CYCLES=4, TIMEOUT_CYC=100) → during reset all outputs are 0. After the 1st SOF: oState=01, oEdgeEn=0 for the whole frame, oFrameCnt=1. After the 2nd SOF: oState=10 and oEdgeEn=1 exactly at X∈[2,5], Y∈[1,2], delayed 1 cycle.
- Switch debounce → iSW pulses high for 3 cycles: debounced value, oModePend and oIsHorz unchanged. iSW held high: oModePend=1 at cycle DEB_CYCLES+3; oIsHorz stays 0 until the next SOF, then becomes 1 and oModePend returns to 0.
- Mode change with MASK_ON_SWITCH=1 → the frame after the applying SOF has oState=01 and oEdgeEn=0 everywhere; the following frame is back in RUN. With MASK_ON_SWITCH=0, oEdgeEn is unaffected across the change.
- Debounce update in the same cycle as SOF → oIsHorz keeps its old value this frame and changes at the next SOF.
- Timeout → stop iDVAL for 100 cycles in RUN: oState=00 and oEdgeEn=0. The next SOF enters WARM. An SOF arriving in the timeout cycle is ignored by the FSM but oFrameCnt still increments.
- Held (0,0) and wrap → iX_Cont=iY_Cont=0 with iDVAL=1 for 5 cycles gives oFrameCnt +1 only. Preloading oFrameCnt to 65535 via 65535 frames (or forced) and one more SOF → 0. Asserting iRST mid-RUN restores all reset values immediately.

Source files
------------

// File: rtl/conv_frame_ctrl_if.sv
// Pixel-stream bundle feeding the frame sequencer.
// Carries data-valid plus the column/row counters.
interface conv_frame_ctrl_if;
  logic        iDVAL;
  logic [10:0] iX_Cont;
  logic [10:0] iY_Cont;

  modport master (
    output iDVAL,
    output iX_Cont,
    output iY_Cont
  );

  modport slave (
    input iDVAL,
    input iX_Cont,
    input iY_Cont
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the Sobel edge path: switch debounce,
// SOF-aligned direction changes, warm-up masking, edge window.
module conv_frame_ctrl #(
  parameter int X_LO           = 10,
  parameter int X_HI           = 1269,
  parameter int Y_LO           = 10,
  parameter int Y_HI           = 939,
  parameter int DEB_CYCLES     = 50000,
  parameter int TIMEOUT_CYC    = 4000000,
  parameter int MASK_ON_SWITCH = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSW,
  conv_frame_ctrl_if.slave     pix,
  output logic                 oIsHorz,
  output logic                 oEdgeEn,
  output logic                 oModePend,
  output logic [15:0]          oFrameCnt,
  output logic [1:0]           oState
);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'b00,
    WARM     = 2'b01,
    RUN      = 2'b10
  } state_t;

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

  localparam logic [10:0] XLO = 11'(X_LO);
  localparam logic [10:0] XHI = 11'(X_HI);
  localparam logic [10:0] YLO = 11'(Y_LO);
  localparam logic [10:0] YHI = 11'(Y_HI);

  state_t        state;
  state_t        stateNxt;
  logic          horzLd;
  logic          swMeta;
  logic          swSync;
  logic          swDeb;
  logic [DW-1:0] debCnt;
  logic [TW-1:0] toCnt;
  logic          timedOut;
  logic          sofArmed;
  logic          sof;
  logic          inWin;

  assign sof = pix.iDVAL
             && (pix.iX_Cont == 11'd0)
             && (pix.iY_Cont == 11'd0)
             && sofArmed;

  assign timedOut = (toCnt == TO_MAX);

  assign inWin = (pix.iX_Cont >= XLO)
              && (pix.iX_Cont <= XHI)
              && (pix.iY_Cont >= YLO)
              && (pix.iY_Cont <= YHI);

  assign oState = state;

  // two-flop synchroniser for the asynchronous switch
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      swMeta <= 1'b0;
      swSync <= 1'b0;
    end else begin
      swMeta <= iSW;
      swSync <= swMeta;
    end
  end

  // accept the switch only after it has been stable long enough
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      swDeb  <= 1'b0;
      debCnt <= '0;
    end else if (swSync == swDeb) begin
      debCnt <= '0;
    end else if (debCnt == DEB_MAX) begin
      swDeb  <= swSync;
      debCnt <= '0;
    end else begin
      debCnt <= debCnt + DW'(1);
    end
  end

  // one SOF per frame: re-armed once the row counter leaves 0
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sofArmed <= 1'b0;
    end else if (sof) begin
      sofArmed <= 1'b0;
    end else if (pix.iY_Cont != 11'd0) begin
      sofArmed <= 1'b1;
    end
  end

  // stream-lost detector, saturating
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      toCnt <= '0;
    end else if (pix.iDVAL) begin
      toCnt <= '0;
    end else if (!timedOut) begin
      toCnt <= toCnt + TW'(1);
    end
  end

  // frame counter, counts every SOF regardless of state
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFrameCnt <= 16'd0;
    end else if (sof) begin
      oFrameCnt <= oFrameCnt + 16'd1;
    end
  end

  // state, applied direction, pending flag and edge enable
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= WAIT_SOF;
      oIsHorz   <= 1'b0;
      oModePend <= 1'b0;
      oEdgeEn   <= 1'b0;
    end else begin
      state     <= stateNxt;
      oModePend <= (swDeb != oIsHorz);
      oEdgeEn   <= (state == RUN) && inWin;
      if (horzLd) begin
        oIsHorz <= swDeb;
      end
    end
  end

  // next state; timeout outranks SOF once the stream was live
  always_comb begin
    stateNxt = state;
    horzLd   = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (sof) begin
          stateNxt = WARM;
          horzLd   = 1'b1;
        end
      end
      WARM: begin
        if (timedOut) begin
          stateNxt = WAIT_SOF;
        end else if (sof) begin
          stateNxt = RUN;
          horzLd   = 1'b1;
        end
      end
      RUN: begin
        if (timedOut) begin
          stateNxt = WAIT_SOF;
        end else if (sof && (swDeb != oIsHorz)) begin
          horzLd   = 1'b1;
          stateNxt = (MASK_ON_SWITCH != 0) ? WARM : RUN;
        end
      end
      default: begin
        stateNxt = WAIT_SOF;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on 8x4 frames, with the
// masking and non-masking variants driven from the same stream.
module tb_conv_frame_ctrl;

  localparam logic [1:0] S_WAIT = 2'b00;
  localparam logic [1:0] S_WARM = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  typedef struct {
    logic       sw;
    logic [1:0] st;
    logic [1:0] st0;
    logic       h;
    logic       h0;
    logic       pend;
  } frame_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  logic iSW  = 1'b0;

  conv_frame_ctrl_if pix();

  logic        h1, e1, p1;
  logic [15:0] fc1;
  logic [1:0]  st1;
  logic        h0, e0, p0;
  logic [15:0] fc0;
  logic [1:0]  st0;

  conv_frame_ctrl #(
    .X_LO(2), .X_HI(5), .Y_LO(1), .Y_HI(2),
    .DEB_CYCLES(4), .TIMEOUT_CYC(100),
    .MASK_ON_SWITCH(1)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSW(iSW), .pix(pix),
    .oIsHorz(h1), .oEdgeEn(e1), .oModePend(p1),
    .oFrameCnt(fc1), .oState(st1)
  );

  conv_frame_ctrl #(
    .X_LO(2), .X_HI(5), .Y_LO(1), .Y_HI(2),
    .DEB_CYCLES(4), .TIMEOUT_CYC(100),
    .MASK_ON_SWITCH(0)
  ) dut0 (
    .iCLK(iCLK), .iRST(iRST), .iSW(iSW), .pix(pix),
    .oIsHorz(h0), .oEdgeEn(e0), .oModePend(p0),
    .oFrameCnt(fc0), .oState(st0)
  );

  always #5 iCLK = ~iCLK;

  int          nCmp = 0;
  int          nErr = 0;
  logic [15:0] ec   = 16'd0;
  frame_t      tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic dv,
                     input int x,
                     input int y);
    pix.iDVAL   = dv;
    pix.iX_Cont = 11'(x);
    pix.iY_Cont = 11'(y);
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic inWin(input int x, input int y);
    return (x >= 2) && (x <= 5) && (y >= 1) && (y <= 2);
  endfunction

  task automatic playFrame(input logic [1:0] es,
                           input logic [1:0] es0,
                           input logic eh,
                           input logic eh0);
    ec = ec + 16'd1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        cyc(1'b1, x, y);
        if (x == 0 && y == 0) begin
          chk("sof_state", st1, es);
          chk("sof_state0", st0, es0);
          chk("sof_horz", h1, eh);
          chk("sof_horz0", h0, eh0);
          chk("sof_fcnt", fc1, ec);
          chk("sof_fcnt0", fc0, ec);
        end else begin
          chk("edge", e1, (es == S_RUN) && inWin(x, y));
          chk("edge0", e0, (es0 == S_RUN) && inWin(x, y));
        end
      end
    end
  endtask

  task automatic chkAllZero(input string nm);
    chk({nm, "_horz"}, h1, 0);
    chk({nm, "_edge"}, e1, 0);
    chk({nm, "_pend"}, p1, 0);
    chk({nm, "_fcnt"}, fc1, 0);
    chk({nm, "_state"}, st1, S_WAIT);
    chk({nm, "_state0"}, st0, S_WAIT);
    chk({nm, "_fcnt0"}, fc0, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, S_WARM, S_WARM, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, S_RUN,  S_RUN,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, S_RUN,  S_RUN,  1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, S_RUN,  S_RUN,  1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, S_WARM, S_RUN,  1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, S_RUN,  S_RUN,  1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, S_RUN,  S_RUN,  1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, S_WARM, S_RUN,  1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, S_RUN,  S_RUN,  1'b0, 1'b0, 1'b0};

    // reset held across clock edges
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 7, 3);
      chkAllZero("rst");
    end
    iRST = 1'b1;
    cyc(1'b1, 7, 3);
    cyc(1'b1, 7, 3);
    chk("idle_state", st1, S_WAIT);

    // frame table: warm-up, switch, mask / no-mask
    for (int i = 0; i < 9; i++) begin
      iSW = tbl[i].sw;
      playFrame(tbl[i].st, tbl[i].st0, tbl[i].h, tbl[i].h0);
      chk("end_pend", p1, tbl[i].pend);
      chk("end_pend0", p0, tbl[i].pend);
    end

    // 3-cycle glitch is rejected
    iSW = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 7, 3);
    iSW = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 7, 3);
      chk("glitch_pend", p1, 0);
    end
    chk("glitch_horz", h1, 0);

    // held switch: pending after DEB_CYCLES+3 edges
    iSW = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, 7, 3);
      chk($sformatf("hold_pend_k%0d", k), p1, (k >= 7));
    end
    chk("hold_horz", h1, 0);
    playFrame(S_WARM, S_RUN, 1'b1, 1'b1);
    chk("apply_pend", p1, 0);
    playFrame(S_RUN, S_RUN, 1'b1, 1'b1);

    // debounce lands on the SOF edge
    iSW = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1'b1, 7, 3);
    playFrame(S_RUN, S_RUN, 1'b1, 1'b1);
    chk("same_pend", p1, 1);
    playFrame(S_WARM, S_RUN, 1'b0, 1'b0);
    playFrame(S_RUN, S_RUN, 1'b0, 1'b0);

    // stream timeout from RUN
    for (int k = 1; k <= 101; k++) begin
      cyc(1'b0, 7, 3);
      if (k == 100) chk("to_state_100", st1, S_RUN);
    end
    chk("to_state", st1, S_WAIT);
    chk("to_state0", st0, S_WAIT);
    chk("to_edge", e1, 0);
    cyc(1'b1, 7, 3);
    playFrame(S_WARM, S_WARM, 1'b0, 1'b0);
    playFrame(S_RUN, S_RUN, 1'b0, 1'b0);

    // SOF in the timeout cycle: counted, not acted on
    cyc(1'b1, 7, 3);
    for (int k = 0; k < 100; k++) cyc(1'b0, 7, 3);
    cyc(1'b1, 0, 0);
    ec = ec + 16'd1;
    chk("tosof_state", st1, S_WAIT);
    chk("tosof_fcnt", fc1, ec);
    cyc(1'b1, 7, 3);
    chk("tosof_state_after", st1, S_WAIT);
    playFrame(S_WARM, S_WARM, 1'b0, 1'b0);

    // held (0,0) gives a single SOF
    cyc(1'b1, 7, 3);
    for (int k = 0; k < 5; k++) cyc(1'b1, 0, 0);
    ec = ec + 16'd1;
    chk("held_fcnt", fc1, ec);
    chk("held_fcnt0", fc0, ec);
    chk("held_state", st1, S_RUN);

    // frame counter wrap
    force dut.oFrameCnt = 16'hFFFF;
    cyc(1'b1, 7, 3);
    release dut.oFrameCnt;
    cyc(1'b1, 7, 3);
    cyc(1'b1, 0, 0);
    chk("wrap_fcnt", fc1, 0);

    // asynchronous reset in the middle of RUN
    cyc(1'b1, 3, 1);
    chk("pre_rst_edge", e1, 1);
    #2;
    iRST = 1'b0;
    #1;
    chkAllZero("midrst");
    iRST = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
